twiddle_gen: RTL and testbench

//  Parametrised twiddle-factor generator for one radix-2 DIF stage of the MDC FFT pipeline.
//  - Replaces per-stage hand-written ROMs with a single block holding a quarter-wave cosine table.
//  - Outputs a sequenced, registered, valid-tagged W_N^e that runs in lock-step with the stage's data stream.

---
 rtl/fft_tw_pkg.sv | 43 ++++
 rtl/twiddle_qrom.sv | 33 +++
 rtl/twiddle_gen.sv | 119 +++++++++++
 tb/tb_twiddle_gen.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/fft_tw_pkg.sv
// rtl/fft_tw_pkg.sv - width helpers, cosine table builder and twiddle type for the MDC FFT twiddle generator
package fft_tw_pkg;

  localparam int DEF_N     = 32;
  localparam int DEF_STAGE = 0;
  localparam int DEF_W     = 9;

  // Counter width: log2(N)-1-STAGE bits, never narrower than one bit
  function automatic int calc_cnt_w(input int n, input int stage);
    int w;
    w = $clog2(n) - 1 - stage;
    return (w < 1) ? 1 : w;
  endfunction

  // Quarter-wave table has N/4+1 entries, addressed 0..N/4
  function automatic int calc_addr_w(input int n);
    return $clog2(n / 4 + 1);
  endfunction

  localparam int CNT_W  = calc_cnt_w(DEF_N, DEF_STAGE);
  localparam int ADDR_W = calc_addr_w(DEF_N);

  typedef logic signed [DEF_W-1:0] tw_t;

  // round(2^(w-2) * cos(2*pi*i/n)) for i in 0..n/4; the angle stays inside [0, pi/2]
  // so a Taylor series converges well and the result is never negative
  function automatic int tw_cos(input int n, input int w, input int i);
    real x;
    real term;
    real sum;
    real scale;
    x     = 6.283185307179586 * real'(i) / real'(n);
    sum   = 1.0;
    term  = 1.0;
    for (int k = 1; k <= 12; k++) begin
      term = -term * x * x / real'((2 * k - 1) * (2 * k));
      sum  = sum + term;
    end
    scale = real'(1 << (w - 2));
    return $rtoi(sum * scale + 0.5);
  endfunction

endpackage

// File: rtl/twiddle_qrom.sv
// rtl/twiddle_qrom.sv - dual-address quarter-wave cosine ROM with registered addresses
module twiddle_qrom
  import fft_tw_pkg::*;
#(
  parameter int N  = 32,
  parameter int W  = 9,
  parameter int AW = calc_addr_w(N)
) (
  input  logic          clk,
  input  logic [AW-1:0] addr_a,
  input  logic [AW-1:0] addr_b,
  output logic [W-1:0]  q_a,
  output logic [W-1:0]  q_b
);

  logic [W-1:0]  rom [0:N/4];
  logic [AW-1:0] addr_a_q;
  logic [AW-1:0] addr_b_q;

  for (genvar gi = 0; gi <= N / 4; gi++) begin : g_rom
    assign rom[gi] = W'(tw_cos(N, W, gi));
  end

  // Address registers form the first pipeline stage of the table read
  always_ff @(posedge clk) begin
    addr_a_q <= addr_a;
    addr_b_q <= addr_b;
  end

  assign q_a = rom[addr_a_q];
  assign q_b = rom[addr_b_q];

endmodule

// File: rtl/twiddle_gen.sv
// rtl/twiddle_gen.sv - sequenced twiddle generator for one radix-2 DIF stage; TWIDDLE_CONJ_EN adds the inverse port
module twiddle_gen
  import fft_tw_pkg::*;
#(
  parameter int N     = 32,
  parameter int STAGE = 0,
  parameter int W     = 9
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                sync,
`ifdef TWIDDLE_CONJ_EN
  input  logic                inverse,
`endif
  output logic                tw_valid,
  output logic signed [W-1:0] w_r,
  output logic signed [W-1:0] w_i
);

  localparam int LOG_N    = $clog2(N);
  localparam int E_W      = LOG_N - 1;
  localparam int CW       = calc_cnt_w(N, STAGE);
  localparam int AW       = calc_addr_w(N);
  localparam int CNT_LAST = (N >> (STAGE + 1)) - 1;
  localparam int QW       = N / 4;

  logic [CW-1:0]  cnt;
  logic [CW-1:0]  cnt_sel;
  logic [E_W-1:0] e;
  logic           quad;
  logic [E_W-2:0] e_lo;
  logic [AW-1:0]  a_dir;
  logic [AW-1:0]  a_mir;
  logic [AW-1:0]  addr_a;
  logic [AW-1:0]  addr_b;
  logic           inv_in;
  logic           p1_valid;
  logic           p1_quad;
  logic           p1_inv;
  logic [W-1:0]   q_a;
  logic [W-1:0]   q_b;

`ifdef TWIDDLE_CONJ_EN
  assign inv_in = inverse;
`else
  assign inv_in = 1'b0;
`endif

  // Sample counter: sync restarts the frame so the next sample is entry 1
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (en) begin
      if (sync) begin
        cnt <= CW'(CNT_LAST == 0 ? 0 : 1);
      end else if (cnt == CW'(CNT_LAST)) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Exponent and quarter-wave folding into two table addresses
  always_comb begin
    cnt_sel = (sync && en) ? '0 : cnt;
    e       = E_W'(cnt_sel) << STAGE;
    quad    = e[E_W-1];
    e_lo    = e[E_W-2:0];
    a_dir   = AW'(e_lo);
    a_mir   = AW'(QW) - AW'(e_lo);
    addr_a  = quad ? a_mir : a_dir;
    addr_b  = quad ? a_dir : a_mir;
  end

  twiddle_qrom #(
    .N  (N),
    .W  (W),
    .AW (AW)
  ) u_qrom (
    .clk    (clk),
    .addr_a (addr_a),
    .addr_b (addr_b),
    .q_a    (q_a),
    .q_b    (q_b)
  );

  // P1 valid: cleared by reset so in-flight samples are dropped
  always_ff @(posedge clk) begin
    if (rst) begin
      p1_valid <= 1'b0;
    end else begin
      p1_valid <= en;
    end
  end

  // P1 side-band: quadrant and conjugate request travel alongside the table address
  always_ff @(posedge clk) begin
    p1_quad <= quad;
    p1_inv  <= inv_in;
  end

  // P2: apply signs to the table read; outputs hold whenever no sample arrives
  always_ff @(posedge clk) begin
    if (rst) begin
      tw_valid <= 1'b0;
      w_r      <= '0;
      w_i      <= '0;
    end else begin
      tw_valid <= p1_valid;
      if (p1_valid) begin
        w_r <= p1_quad ? -$signed(q_a) : $signed(q_a);
        w_i <= p1_inv  ?  $signed(q_b) : -$signed(q_b);
      end
    end
  end

endmodule

// File: tb/tb_twiddle_gen.sv
// tb/tb_twiddle_gen.sv - directed table-driven bench for twiddle_gen (STAGE 0 and STAGE 3 instances)
module tb_twiddle_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic en0, sync0, inv0;
  logic en3, sync3;
  logic tv0, tv3;
  logic signed [8:0] wr0, wi0, wr3, wi3;

  int checks   = 0;
  int failures = 0;

  twiddle_gen #(.N(32), .STAGE(0), .W(9)) dut0 (
    .clk      (clk),
    .rst      (rst),
    .en       (en0),
    .sync     (sync0),
`ifdef TWIDDLE_CONJ_EN
    .inverse  (inv0),
`endif
    .tw_valid (tv0),
    .w_r      (wr0),
    .w_i      (wi0)
  );

  twiddle_gen #(.N(32), .STAGE(3), .W(9)) dut3 (
    .clk      (clk),
    .rst      (rst),
    .en       (en3),
    .sync     (sync3),
`ifdef TWIDDLE_CONJ_EN
    .inverse  (1'b0),
`endif
    .tw_valid (tv3),
    .w_r      (wr3),
    .w_i      (wi3)
  );

  typedef struct {
    logic en;
    logic sync;
    logic inv;
    int   exp_v;
    int   exp_r;
    int   exp_i;
  } vec_t;

  vec_t vecs[$];

  // Hand-computed forward twiddles for N=32, W=9, e = 0..15
  int er[16] = '{128, 126, 118, 106,  91,  71,  49,  25,
                   0, -25, -49, -71, -91,-106,-118,-126};
  int ei[16] = '{  0, -25, -49, -71, -91,-106,-118,-126,
                -128,-126,-118,-106, -91, -71, -49, -25};

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic add(input logic e_n, input logic s, input logic iv,
                     input int v, input int r, input int i);
    vec_t t;
    t.en = e_n; t.sync = s; t.inv = iv; t.exp_v = v; t.exp_r = r; t.exp_i = i;
    vecs.push_back(t);
  endtask

  function automatic int rnd(input real x);
    return (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(-x + 0.5);
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; en0 = 1'b0; sync0 = 1'b0; inv0 = 1'b0; en3 = 1'b0; sync3 = 1'b0;
    step; step; step;
    chk("rst_valid0", tv0, 0);
    chk("rst_wr0",    wr0, 0);
    chk("rst_wi0",    wi0, 0);
    chk("rst_valid3", tv3, 0);
    chk("rst_wr3",    wr3, 0);
    chk("rst_wi3",    wi3, 0);
    rst = 1'b0;

    // STAGE=3: en from two cycles after reset, outputs alternate e=0 / e=8
    step; step;
    chk("s3_idle_valid", tv3, 0);
    en3 = 1'b1;
    step;
    chk("s3_lat1_valid", tv3, 0);
    for (int k = 0; k < 4; k++) begin
      step;
      chk("s3_valid", tv3, 1);
      chk("s3_wr", wr3, (k % 2 == 0) ? 128 : 0);
      chk("s3_wi", wi3, (k % 2 == 0) ? 0 : -128);
    end
    en3 = 1'b0;

    // STAGE=0 vector table: full wrap, en gaps after sync, sync mid-frame
    for (int k = 0; k < 17; k++) add(1, 0, 0, 1, er[k % 16], ei[k % 16]);
    add(1, 1, 0, 1, 128, 0);
    add(0, 0, 0, 0, 128, 0);
    add(0, 0, 0, 0, 128, 0);
    add(1, 0, 0, 1, 126, -25);
    add(1, 0, 0, 1, 118, -49);
    add(1, 0, 0, 1, 106, -71);
    add(1, 0, 0, 1,  91, -91);
    add(1, 1, 0, 1, 128, 0);
    add(1, 0, 0, 1, 126, -25);
    add(1, 0, 0, 1, 118, -49);

    for (int i = 0; i <= vecs.size(); i++) begin
      if (i < vecs.size()) begin
        en0 = vecs[i].en; sync0 = vecs[i].sync; inv0 = vecs[i].inv;
      end else begin
        en0 = 1'b0; sync0 = 1'b0; inv0 = 1'b0;
      end
      step;
      if (i >= 1) begin
        chk($sformatf("vec%0d_valid", i - 1), tv0, vecs[i-1].exp_v);
        chk($sformatf("vec%0d_wr", i - 1),    wr0, vecs[i-1].exp_r);
        chk($sformatf("vec%0d_wi", i - 1),    wi0, vecs[i-1].exp_i);
      end
    end

    // Reset with two samples in flight
    en0 = 1'b1;
    step; step;
    rst = 1'b1;
    step;
    chk("rst_flight_valid", tv0, 0);
    chk("rst_flight_wr",    wr0, 0);
    chk("rst_flight_wi",    wi0, 0);
    rst = 1'b0; en0 = 1'b0;
    step;
    chk("rst_drop_valid", tv0, 0);
    en0 = 1'b1;
    step;
    en0 = 1'b0;
    step;
    chk("post_rst_valid", tv0, 1);
    chk("post_rst_wr",    wr0, 128);
    chk("post_rst_wi",    wi0, 0);
    step;
    chk("post_rst_idle",  tv0, 0);
    chk("post_rst_hold",  wr0, 128);

`ifdef TWIDDLE_CONJ_EN
    // Conjugate per sample, against a real-valued reference
    begin
      int   pe;
      logic pinv;
      pe = 0; pinv = 1'b0;
      for (int k = 0; k <= 16; k++) begin
        if (k < 16) begin
          en0 = 1'b1; sync0 = (k == 0); inv0 = 1'(((k & 1) ^ ((k >> 3) & 1)));
        end else begin
          en0 = 1'b0; sync0 = 1'b0; inv0 = 1'b0;
        end
        step;
        if (k >= 1) begin
          real th;
          int  mr, mi;
          th = 6.283185307179586 * real'(pe) / 32.0;
          mr = rnd(128.0 * $cos(th));
          mi = -rnd(128.0 * $sin(th));
          if (pinv) mi = -mi;
          chk($sformatf("conj_e%0d_valid", pe), tv0, 1);
          chk($sformatf("conj_e%0d_wr", pe), wr0, mr);
          chk($sformatf("conj_e%0d_wi", pe), wi0, mi);
          if (pe == 8) chk("conj_e8_hand_wi", wi0, 128);
          if (pe == 4) chk("conj_e4_hand_wi", wi0, -91);
        end
        pe = k; pinv = inv0;
      end
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
